mavg_stream: RTL

Streaming, parametrised moving-average (boxcar) filter for ADC sample data, up to several time-multiplexed channels. It replaces whole-array batch filtering with a per-sample valid/ready pipeline. Each accepted sample updates a per-channel running sum over the last WIN samples and emits floor(sum/WIN). It sits between the ADC capture path and the downstream logging/DSP stages.

---
 rtl/mavg_stream.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mavg_stream.sv
`default_nettype none
// ============================================================================
// Module : mavg_stream
// Brief  : Multi-channel streaming boxcar filter, emits floor(sum/WIN) per sample
// Rev    : 1.0  initial release
// ============================================================================
module mavg_stream #(
  parameter int DATA_W = 8,
  parameter int WIN    = 5,
  parameter int CH     = 1,
  parameter int PRIME  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_W-1:0]                      in_data,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] in_ch,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_W-1:0]                      out_data,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
  output logic                                   err_ch
);

  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int PTR_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int FILL_W = $clog2(WIN + 1);
  localparam int SUM_W  = DATA_W + FILL_W;

  localparam logic [CH_W:0]     c_ch_num    = (CH_W + 1)'(CH);
  localparam logic [PTR_W-1:0]  c_ptr_last  = PTR_W'(WIN - 1);
  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(WIN);
  localparam logic [SUM_W-1:0]  c_win       = SUM_W'(WIN);

  logic [DATA_W-1:0] r_buf  [CH][WIN];
  logic [SUM_W-1:0]  r_sum  [CH];
  logic [PTR_W-1:0]  r_ptr  [CH];
  logic [FILL_W-1:0] r_fill [CH];

  logic              r_s1_valid;
  logic [SUM_W-1:0]  r_s1_sum;
  logic [CH_W-1:0]   r_s1_ch;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic              r_err_ch;

  logic              w_advance;
  logic              w_accept;
  logic              w_ch_ok;
  logic              w_emit;
  logic [CH_W-1:0]   w_cidx;
  logic [DATA_W-1:0] w_oldest;
  logic [SUM_W-1:0]  w_sum_nxt;
  logic [SUM_W-1:0]  w_quot;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [FILL_W-1:0] w_fill_nxt;

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance && !clear && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_ch_ok   = {1'b0, in_ch} < c_ch_num;
  // Out-of-range tags read channel 0 but never commit, keeping indices in bounds.
  assign w_cidx    = w_ch_ok ? in_ch : '0;
  assign w_oldest  = r_buf[w_cidx][r_ptr[w_cidx]];

  assign w_sum_nxt  = r_sum[w_cidx] + {{FILL_W{1'b0}}, in_data} - {{FILL_W{1'b0}}, w_oldest};
  assign w_fill_nxt = (r_fill[w_cidx] == c_fill_full) ? c_fill_full : r_fill[w_cidx] + FILL_W'(1);
  assign w_ptr_nxt  = (r_ptr[w_cidx] == c_ptr_last) ? '0 : r_ptr[w_cidx] + PTR_W'(1);
  assign w_emit     = (PRIME != 0) || (w_fill_nxt == c_fill_full);
  assign w_quot     = r_s1_sum / c_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        r_sum[c]  <= '0;
        r_ptr[c]  <= '0;
        r_fill[c] <= '0;
        for (int i = 0; i < WIN; i++) r_buf[c][i] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CH; c++) begin
        r_sum[c]  <= '0;
        r_ptr[c]  <= '0;
        r_fill[c] <= '0;
        for (int i = 0; i < WIN; i++) r_buf[c][i] <= '0;
      end
    end else if (w_accept && w_ch_ok) begin
      r_buf[w_cidx][r_ptr[w_cidx]] <= in_data;
      r_sum[w_cidx]  <= w_sum_nxt;
      r_ptr[w_cidx]  <= w_ptr_nxt;
      r_fill[w_cidx] <= w_fill_nxt;
    end
  end

  // Both stages move together; a held stage 2 also freezes stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_ch     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_err_ch    <= 1'b0;
    end else if (clear) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_ch    <= 1'b0;
    end else begin
      r_err_ch <= w_accept && !w_ch_ok;
      if (w_advance) begin
        r_s1_valid  <= w_accept && w_ch_ok && w_emit;
        r_s1_sum    <= w_sum_nxt;
        r_s1_ch     <= w_cidx;
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_quot[DATA_W-1:0];
          r_out_ch   <= r_s1_ch;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign err_ch    = r_err_ch;

endmodule
`default_nettype wire
